// File: rtl/mfp_seven_segment_scan_controller_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds the scan FSM encoding and the active-low {g,f,e,d,c,b,a} glyph table.
package mfp_seven_segment_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_LIT   = 2'd2,
    ST_DARK  = 2'd3
  } scan_state_e;

  // All segments off (active-low).
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  // Hex glyphs, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/mfp_seven_segment_scan_controller_hex_to_seven_segments.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module mfp_hex_to_seven_segments
  import mfp_seven_segment_scan_controller_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seven_segments
);

  // Look up the glyph for the nibble; unknown codes blank the digit.
  always_comb begin
    seven_segments = SEG_OFF;
    case (hex)
      4'h0:    seven_segments = SEG_HEX_0;
      4'h1:    seven_segments = SEG_HEX_1;
      4'h2:    seven_segments = SEG_HEX_2;
      4'h3:    seven_segments = SEG_HEX_3;
      4'h4:    seven_segments = SEG_HEX_4;
      4'h5:    seven_segments = SEG_HEX_5;
      4'h6:    seven_segments = SEG_HEX_6;
      4'h7:    seven_segments = SEG_HEX_7;
      4'h8:    seven_segments = SEG_HEX_8;
      4'h9:    seven_segments = SEG_HEX_9;
      4'hA:    seven_segments = SEG_HEX_A;
      4'hB:    seven_segments = SEG_HEX_B;
      4'hC:    seven_segments = SEG_HEX_C;
      4'hD:    seven_segments = SEG_HEX_D;
      4'hE:    seven_segments = SEG_HEX_E;
      4'hF:    seven_segments = SEG_HEX_F;
      default: seven_segments = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/mfp_seven_segment_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit slot is: anti-ghost blank ticks, then brightness-controlled lit
// ticks, then dark ticks. Number/dots/zero-suppression mask are captured at
// frame start so a frame never shows a mix of old and new values.
// A suppressed leading-zero digit whose dot bit is set still selects its
// anode with all segments off, so the decimal point alone is visible.
// N_DIGITS must be at least 2.
module mfp_seven_segment_scan_controller
  import mfp_seven_segment_scan_controller_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SLOT_TICKS  = 16,
  parameter int BLANK_TICKS = 1,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    tick,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   number,
  input  logic [N_DIGITS-1:0]     dots,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seven_segments,
  output logic                    dot,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_start
);

  localparam int TW = $clog2(SLOT_TICKS);
  localparam int DW = $clog2(N_DIGITS);

  localparam logic [TW-1:0]       T_LAST    = TW'(SLOT_TICKS - 1);
  localparam logic [DW-1:0]       D_LAST    = DW'(N_DIGITS - 1);
  localparam logic [31:0]         MAX_LIT   = 32'(SLOT_TICKS - BLANK_TICKS);
  localparam logic [31:0]         BLANK_END = 32'(BLANK_TICKS);
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{1'b1}};
  localparam logic [N_DIGITS-1:0] AN_ONE    = {{(N_DIGITS-1){1'b0}}, 1'b1};

  scan_state_e             state_r, state_nxt_s, phase_s;
  logic [TW-1:0]           t_r, t_nxt_s;
  logic [DW-1:0]           digit_r, digit_nxt_s;
  logic                    snap_load_s;
  logic                    frame_start_nxt_s;

  logic [4*N_DIGITS-1:0]   number_r;
  logic [N_DIGITS-1:0]     dots_r;
  logic [N_DIGITS-1:0]     supp_r, supp_s;

  logic [31:0]             lit_ticks_s;
  logic [31:0]             t_inc_s;
  logic [3:0]              nibble_s;
  logic [6:0]              dec_seg_s;

  logic [6:0]              seg_r, seg_nxt_s;
  logic                    dot_r, dot_nxt_s;
  logic [N_DIGITS-1:0]     anodes_r, anodes_nxt_s;
  logic                    frame_start_r;

  // Lit length for this slot, saturated so blanking plus lit never exceeds the slot.
  always_comb begin
    if (32'(brightness) < MAX_LIT) begin
      lit_ticks_s = 32'(brightness);
    end else begin
      lit_ticks_s = MAX_LIT;
    end
  end

  // Phase the slot will be in once the tick counter advances by one.
  always_comb begin
    t_inc_s = 32'(t_r) + 32'd1;
    if (t_inc_s < BLANK_END) begin
      phase_s = ST_BLANK;
    end else if (t_inc_s < (BLANK_END + lit_ticks_s)) begin
      phase_s = ST_LIT;
    end else begin
      phase_s = ST_DARK;
    end
  end

  // Leading-zero mask: digit i is blanked when it and every higher nibble are zero.
  always_comb begin : lz_mask
    logic zero_tail_v;
    zero_tail_v = 1'b1;
    supp_s      = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_tail_v = zero_tail_v & (number[4*i +: 4] == 4'h0);
      if (i > 0) begin
        supp_s[i] = lz_suppress & zero_tail_v;
      end else begin
        supp_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic: scan advances only on tick; dropping enable parks in IDLE.
  always_comb begin
    state_nxt_s       = state_r;
    t_nxt_s           = t_r;
    digit_nxt_s       = digit_r;
    snap_load_s       = 1'b0;
    frame_start_nxt_s = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      t_nxt_s     = {TW{1'b0}};
      digit_nxt_s = {DW{1'b0}};
    end else if (tick) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s       = ST_BLANK;
          t_nxt_s           = {TW{1'b0}};
          digit_nxt_s       = {DW{1'b0}};
          snap_load_s       = 1'b1;
          frame_start_nxt_s = 1'b1;
        end
        ST_BLANK, ST_LIT, ST_DARK: begin
          if (t_r == T_LAST) begin
            state_nxt_s = ST_BLANK;
            t_nxt_s     = {TW{1'b0}};
            if (digit_r == D_LAST) begin
              digit_nxt_s       = {DW{1'b0}};
              snap_load_s       = 1'b1;
              frame_start_nxt_s = 1'b1;
            end else begin
              digit_nxt_s = digit_r + {{(DW-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nxt_s = phase_s;
            t_nxt_s     = t_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          t_nxt_s     = {TW{1'b0}};
          digit_nxt_s = {DW{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Scan FSM, slot tick counter and digit counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      t_r     <= {TW{1'b0}};
      digit_r <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      t_r     <= t_nxt_s;
      digit_r <= digit_nxt_s;
    end
  end

  // Frame snapshot of the displayed value, dots and suppression mask.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      number_r <= {(4*N_DIGITS){1'b0}};
      dots_r   <= {N_DIGITS{1'b0}};
      supp_r   <= {N_DIGITS{1'b0}};
    end else if (snap_load_s) begin
      number_r <= number;
      dots_r   <= dots;
      supp_r   <= supp_s;
    end else begin
      number_r <= number_r;
    end
  end

  assign nibble_s = number_r[{digit_nxt_s, 2'b00} +: 4];

  mfp_hex_to_seven_segments u_hex (
    .hex            (nibble_s),
    .seven_segments (dec_seg_s)
  );

  // Pin values for the next clock; segments only move together with the anodes.
  always_comb begin
    seg_nxt_s    = seg_r;
    dot_nxt_s    = dot_r;
    anodes_nxt_s = anodes_r;
    if (!enable) begin
      seg_nxt_s    = SEG_OFF;
      dot_nxt_s    = 1'b1;
      anodes_nxt_s = AN_OFF;
    end else if (tick) begin
      seg_nxt_s    = SEG_OFF;
      dot_nxt_s    = 1'b1;
      anodes_nxt_s = AN_OFF;
      if (state_nxt_s == ST_LIT) begin
        if (!supp_r[digit_nxt_s]) begin
          anodes_nxt_s = ~(AN_ONE << digit_nxt_s);
          seg_nxt_s    = dec_seg_s;
          dot_nxt_s    = ~dots_r[digit_nxt_s];
        end else if (dots_r[digit_nxt_s]) begin
          anodes_nxt_s = ~(AN_ONE << digit_nxt_s);
          dot_nxt_s    = 1'b0;
        end else begin
          anodes_nxt_s = AN_OFF;
        end
      end else begin
        anodes_nxt_s = AN_OFF;
      end
    end else begin
      anodes_nxt_s = anodes_r;
    end
  end

  // Registered pin drivers and frame-start pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_r         <= SEG_OFF;
      dot_r         <= 1'b1;
      anodes_r      <= AN_OFF;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= seg_nxt_s;
      dot_r         <= dot_nxt_s;
      anodes_r      <= anodes_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign seven_segments = seg_r;
  assign dot            = dot_r;
  assign anodes         = anodes_r;
  assign frame_start    = frame_start_r;

endmodule
